alu_issue_stage: RTL and testbench

//  Producer end of the ALU operand/control interface: decodes opcode/funct fields into
//  the 4-bit ALU control code, selects SrcA/SrcB, and registers them toward the ALU.

---
 rtl/alu_pkg.sv | 58 +++++
 rtl/alu_decoder.sv | 58 +++++
 rtl/alu_issue_stage.sv | 151 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: ALU operation codes, operand
// selects, the decoded-entry struct, skid FSM states, opcode constants
// and the funct3 -> ALU operation helper.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {SRC_A_ZERO, SRC_A_RS1, SRC_A_PC} src_a_e;
  typedef enum logic [1:0] {SRC_B_ZERO, SRC_B_RS2, SRC_B_IMM} src_b_e;

  typedef struct packed {
    alu_op_e op;
    src_a_e  a_sel;
    src_b_e  b_sel;
    logic    illegal;
  } alu_dec_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} skid_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Register/immediate arithmetic funct3 map; alt selects SUB/SRA.
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Purely combinational opcode/funct decode into ALU control code,
// operand selects and an illegal flag. Illegal encodings decode to
// ADD with both operands forced to zero.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output alu_dec_t   o_dec
);

  // Decode instruction class and funct fields.
  always_comb begin
    o_dec = '{op: ALU_ADD, a_sel: SRC_A_ZERO, b_sel: SRC_B_ZERO, illegal: 1'b0};
    case (i_opcode)
      OPC_OP: begin
        o_dec.a_sel = SRC_A_RS1;
        o_dec.b_sel = SRC_B_RS2;
        o_dec.op    = f3_to_op(i_funct3, i_funct7b5);
        if (i_funct7b5 && (i_funct3 != 3'b000) && (i_funct3 != 3'b101))
          o_dec.illegal = 1'b1;
      end
      OPC_OPIMM: begin
        // funct7b5 is an immediate bit except for the shift-right form.
        o_dec.a_sel = SRC_A_RS1;
        o_dec.b_sel = SRC_B_IMM;
        o_dec.op    = f3_to_op(i_funct3, i_funct7b5 && (i_funct3 == 3'b101));
      end
      OPC_LUI: begin
        o_dec.op    = ALU_PASSB;
        o_dec.b_sel = SRC_B_IMM;
      end
      OPC_AUIPC, OPC_JAL: begin
        o_dec.a_sel = SRC_A_PC;
        o_dec.b_sel = SRC_B_IMM;
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        o_dec.a_sel = SRC_A_RS1;
        o_dec.b_sel = SRC_B_IMM;
      end
      OPC_BRANCH: begin
        o_dec.a_sel = SRC_A_RS1;
        o_dec.b_sel = SRC_B_RS2;
        case (i_funct3[2:1])
          2'b00:   o_dec.op = ALU_SUB;
          2'b10:   o_dec.op = ALU_SLT;
          2'b11:   o_dec.op = ALU_SLTU;
          default: o_dec.illegal = 1'b1;
        endcase
      end
      default: o_dec.illegal = 1'b1;
    endcase
    if (o_dec.illegal)
      o_dec = '{op: ALU_ADD, a_sel: SRC_A_ZERO, b_sel: SRC_B_ZERO, illegal: 1'b1};
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes, selects SrcA/SrcB and registers them toward
// the ALU behind a valid/ready handshake.
// Optional macro ALU_ISSUE_SKID_EN: 2-entry skid buffer with registered
// ready_o; otherwise a single output register with combinational ready_o.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [6:0]            opcode_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7b5_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] SrcA_o,
  output logic [DATA_WIDTH-1:0] SrcB_o,
  output logic [3:0]            ALUControl_o,
  output logic                  illegal_o
);

  // Entry layout: {illegal, ALUControl, SrcA, SrcB}.
  localparam int EW = 2 * DATA_WIDTH + 5;

  alu_dec_t              w_dec;
  logic [DATA_WIDTH-1:0] w_src_a;
  logic [DATA_WIDTH-1:0] w_src_b;
  logic [EW-1:0]         w_entry;
  logic [EW-1:0]         r_head;
  logic                  w_in;
  logic                  w_out;

  alu_decoder u_dec (
    .i_opcode   (opcode_i),
    .i_funct3   (funct3_i),
    .i_funct7b5 (funct7b5_i),
    .o_dec      (w_dec)
  );

  // Operand selection from decoded selects.
  always_comb begin
    case (w_dec.a_sel)
      SRC_A_RS1: w_src_a = rs1_data_i;
      SRC_A_PC:  w_src_a = pc_i;
      default:   w_src_a = '0;
    endcase
    case (w_dec.b_sel)
      SRC_B_RS2: w_src_b = rs2_data_i;
      SRC_B_IMM: w_src_b = imm_i;
      default:   w_src_b = '0;
    endcase
  end

  assign w_entry = {w_dec.illegal, w_dec.op, w_src_a, w_src_b};
  assign {illegal_o, ALUControl_o, SrcA_o, SrcB_o} = r_head;

`ifdef ALU_ISSUE_SKID_EN
  skid_state_e   r_state;
  skid_state_e   w_state_next;
  logic [EW-1:0] r_tail;
  logic          r_ready;

  assign ready_o = r_ready;
  assign valid_o = (r_state != ST_EMPTY);
  assign w_in    = valid_i & r_ready;
  assign w_out   = valid_o & ready_i;

  // Skid occupancy state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_EMPTY;
    else         r_state <= w_state_next;
  end

  // Next occupancy; flush always empties the buffer.
  always_comb begin
    w_state_next = r_state;
    if (flush_i) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in) w_state_next = ST_ONE;
        ST_ONE: begin
          if (w_in && !w_out)      w_state_next = ST_TWO;
          else if (!w_in && w_out) w_state_next = ST_EMPTY;
        end
        ST_TWO:   if (w_out) w_state_next = ST_ONE;
        default:  w_state_next = ST_EMPTY;
      endcase
    end
  end

  // Registered ready so ready_i never reaches ready_o combinationally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ready <= 1'b1;
    else         r_ready <= (w_state_next != ST_TWO);
  end

  // Head/tail data movement; the head always drives the outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (flush_i) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in) r_head <= w_entry;
        ST_ONE: begin
          if (w_in && w_out) r_head <= w_entry;
          else if (w_in)     r_tail <= w_entry;
        end
        ST_TWO:   if (w_out) r_head <= r_tail;
        default:  r_head <= '0;
      endcase
    end
  end
`else
  logic r_valid;

  assign valid_o = r_valid;
  assign ready_o = !r_valid | ready_i;
  assign w_in    = valid_i & ready_o;
  assign w_out   = r_valid & ready_i;

  // Single output register; flush wins over a same-cycle input transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_head  <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_head  <= '0;
    end else if (w_in) begin
      r_valid <= 1'b1;
      r_head  <= w_entry;
    end else if (w_out) begin
      r_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni, flush_i, valid_i, ready_i, funct7b5_i;
  logic        ready_o, valid_o, illegal_o;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i, pc_i, SrcA_o, SrcB_o;
  logic [3:0]  ALUControl_o;

  int compared = 0;
  int mismatched = 0;

`ifdef ALU_ISSUE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct packed {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } vec_t;

  vec_t vecs[16];

  alu_issue_stage #(.DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .funct7b5_i(funct7b5_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i), .pc_i(pc_i), .valid_o(valid_o), .ready_i(ready_i),
    .SrcA_o(SrcA_o), .SrcB_o(SrcB_o), .ALUControl_o(ALUControl_o),
    .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input vec_t v);
    opcode_i = v.opc; funct3_i = v.f3; funct7b5_i = v.f7;
    rs1_data_i = v.rs1; rs2_data_i = v.rs2; imm_i = v.imm; pc_i = v.pc;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 0; valid_i = 0; ready_i = 0;
    drive('0);
    #12;
    compared++; if (valid_o !== 1'b0) begin mismatched++; $display("FAIL rst_valid got %b want 0", valid_o); end
    compared++; if (illegal_o !== 1'b0) begin mismatched++; $display("FAIL rst_illegal got %b want 0", illegal_o); end
    compared++; if (SrcA_o !== 32'h0 || SrcB_o !== 32'h0) begin mismatched++; $display("FAIL rst_src got %h/%h want 0/0", SrcA_o, SrcB_o); end
    compared++; if (ALUControl_o !== 4'h0) begin mismatched++; $display("FAIL rst_ctrl got %h want 0", ALUControl_o); end
    @(negedge clk_i); rst_ni = 1'b1; #1;
    compared++; if (ready_o !== 1'b1) begin mismatched++; $display("FAIL rst_ready got %b want 1", ready_o); end
  endtask

  task automatic test_decode();
    vecs[0]  = '{7'h33,3'd0,1'b1,32'd5,32'd3,32'd0,32'd0,4'h1,32'd5,32'd3,1'b0};
    vecs[1]  = '{7'h13,3'd0,1'b1,32'd7,32'd9,32'h400,32'd0,4'h0,32'd7,32'h400,1'b0};
    vecs[2]  = '{7'h37,3'd0,1'b0,32'd9,32'd1,32'h12345000,32'h44,4'hF,32'd0,32'h12345000,1'b0};
    vecs[3]  = '{7'h7F,3'd0,1'b0,32'd1,32'd2,32'd3,32'd4,4'h0,32'd0,32'd0,1'b1};
    vecs[4]  = '{7'h33,3'd5,1'b1,32'h80000000,32'd4,32'd0,32'd0,4'h7,32'h80000000,32'd4,1'b0};
    vecs[5]  = '{7'h33,3'd6,1'b1,32'h11,32'h22,32'd0,32'd0,4'h0,32'd0,32'd0,1'b1};
    vecs[6]  = '{7'h13,3'd5,1'b1,32'hF0,32'h77,32'h404,32'd0,4'h7,32'hF0,32'h404,1'b0};
    vecs[7]  = '{7'h17,3'd0,1'b0,32'hAA,32'd0,32'h2000,32'h1000,4'h0,32'h1000,32'h2000,1'b0};
    vecs[8]  = '{7'h63,3'd6,1'b0,32'd3,32'd8,32'h10,32'd0,4'h9,32'd3,32'd8,1'b0};
    vecs[9]  = '{7'h63,3'd2,1'b0,32'd3,32'd8,32'h10,32'd0,4'h0,32'd0,32'd0,1'b1};
    vecs[10] = '{7'h6F,3'd0,1'b0,32'd1,32'd2,32'd8,32'h200,4'h0,32'h200,32'd8,1'b0};
    vecs[11] = '{7'h23,3'd2,1'b0,32'h100,32'd5,32'hFFFFFFFC,32'd0,4'h0,32'h100,32'hFFFFFFFC,1'b0};
    vecs[12] = '{7'h33,3'd2,1'b0,32'd1,32'd2,32'd0,32'd0,4'h8,32'd1,32'd2,1'b0};
    vecs[13] = '{7'h13,3'd4,1'b1,32'hF,32'd0,32'hFF,32'd0,4'h4,32'hF,32'hFF,1'b0};
    vecs[14] = '{7'h67,3'd0,1'b0,32'h40,32'd9,32'd4,32'h300,4'h0,32'h40,32'd4,1'b0};
    vecs[15] = '{7'h33,3'd0,1'b0,32'd5,32'd3,32'd0,32'd0,4'h0,32'd5,32'd3,1'b0};
    ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]); valid_i = 1'b1;
      step();
      compared++; if (valid_o !== 1'b1) begin mismatched++; $display("FAIL dec%0d_valid got %b want 1", i, valid_o); end
      compared++; if (ALUControl_o !== vecs[i].ctrl) begin mismatched++; $display("FAIL dec%0d_ctrl got %h want %h", i, ALUControl_o, vecs[i].ctrl); end
      compared++; if (SrcA_o !== vecs[i].a) begin mismatched++; $display("FAIL dec%0d_srca got %h want %h", i, SrcA_o, vecs[i].a); end
      compared++; if (SrcB_o !== vecs[i].b) begin mismatched++; $display("FAIL dec%0d_srcb got %h want %h", i, SrcB_o, vecs[i].b); end
      compared++; if (illegal_o !== vecs[i].ill) begin mismatched++; $display("FAIL dec%0d_illegal got %b want %b", i, illegal_o, vecs[i].ill); end
    end
    valid_i = 1'b0;
    step();
    compared++; if (valid_o !== 1'b0) begin mismatched++; $display("FAIL dec_drain got %b want 0", valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a[3];
    int sent = 0;
    int recvd = 0;
    int held;
    logic acc, out, exp_ready;
    vec_t v;
    exp_a[0] = 32'd10; exp_a[1] = 32'd20; exp_a[2] = 32'd30;
    v = vecs[15];
    for (int cyc = 0; cyc < 20; cyc++) begin
      ready_i = (cyc >= 4);
      valid_i = (sent < 3);
      v.rs1 = exp_a[(sent < 3) ? sent : 2];
      drive(v);
      #1;
      held = sent - recvd;
      exp_ready = (DEPTH == 2) ? (held < 2) : ((held == 0) || ready_i);
      compared++; if (ready_o !== exp_ready) begin mismatched++; $display("FAIL bp_ready cyc%0d got %b want %b", cyc, ready_o, exp_ready); end
      compared++; if (valid_o !== (held > 0)) begin mismatched++; $display("FAIL bp_valid cyc%0d got %b want %b", cyc, valid_o, held > 0); end
      if (held > 0) begin
        compared++; if (SrcA_o !== exp_a[recvd] || SrcB_o !== 32'd3) begin mismatched++; $display("FAIL bp_order cyc%0d got %h/%h want %h/3", cyc, SrcA_o, SrcB_o, exp_a[recvd]); end
      end
      acc = valid_i & ready_o;
      out = valid_o & ready_i;
      step();
      if (acc) sent++;
      if (out) recvd++;
    end
    valid_i = 1'b0;
    compared++; if (recvd != 3) begin mismatched++; $display("FAIL bp_count got %0d want 3", recvd); end
  endtask

  task automatic test_flush();
    vec_t v;
    v = vecs[15]; v.rs1 = 32'h55;
    ready_i = 1'b1; drive(v); valid_i = 1'b1; flush_i = 1'b1; #1;
    compared++; if (ready_o !== 1'b1) begin mismatched++; $display("FAIL fl_ready got %b want 1", ready_o); end
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    compared++; if (valid_o !== 1'b0) begin mismatched++; $display("FAIL fl_valid got %b want 0", valid_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      compared++; if (valid_o !== 1'b0) begin mismatched++; $display("FAIL fl_emit%0d got %b want 0", i, valid_o); end
    end
    ready_i = 1'b0; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    compared++; if (valid_o !== 1'b1 || SrcA_o !== 32'h55) begin mismatched++; $display("FAIL fl_load got %b/%h want 1/55", valid_o, SrcA_o); end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    compared++; if (valid_o !== 1'b0) begin mismatched++; $display("FAIL fl_held got %b want 0", valid_o); end
  endtask

  task automatic test_reset_mid_stall();
    ready_i = 1'b0; drive(vecs[4]); valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    compared++; if (valid_o !== 1'b1 || ALUControl_o !== 4'h7) begin mismatched++; $display("FAIL rs_load got %b/%h want 1/7", valid_o, ALUControl_o); end
    #2 rst_ni = 1'b0;
    #1;
    compared++; if (valid_o !== 1'b0 || ALUControl_o !== 4'h0) begin mismatched++; $display("FAIL rs_async got %b/%h want 0/0", valid_o, ALUControl_o); end
    compared++; if (SrcA_o !== 32'h0 || SrcB_o !== 32'h0) begin mismatched++; $display("FAIL rs_src got %h/%h want 0/0", SrcA_o, SrcB_o); end
    @(negedge clk_i); rst_ni = 1'b1; #1;
    compared++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin mismatched++; $display("FAIL rs_release got %b/%b want 1/0", ready_o, valid_o); end
    step();
    compared++; if (valid_o !== 1'b0) begin mismatched++; $display("FAIL rs_idle got %b want 0", valid_o); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
